// File: rtl/c1541_sd_responder_pkg.sv
// rtl/c1541_sd_responder_pkg.sv - shared constants and FSM encoding for the c1541 SD responder
package c1541_sd_pkg;

    localparam int         TRACK_BYTES_DEF = 8192;
    localparam logic [7:0] FILL_BYTE       = 8'h00;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RD_REQ  = 3'd1;
    localparam state_t ST_RD_GAP  = 3'd2;
    localparam state_t ST_WR_ADDR = 3'd3;
    localparam state_t ST_WR_DATA = 3'd4;
    localparam state_t ST_WR_GAP  = 3'd5;
    localparam state_t ST_FINISH  = 3'd6;

endpackage

// File: rtl/c1541_sd_responder_if.sv
// rtl/c1541_sd_responder_if.sv - track-buffer SD handshake plus disk-image memory port
interface c1541_sd_responder_if #(
    parameter int BAW = 13,
    parameter int MAW = 20
);
    logic [31:0]    sd_lba;
    logic           sd_rd;
    logic           sd_wr;
    logic           sd_ack;
    logic [BAW-1:0] sd_buff_addr;
    logic [7:0]     sd_buff_dout;
    logic [7:0]     sd_buff_din;
    logic           sd_buff_wr;
    logic [MAW-1:0] mem_addr;
    logic           mem_rd;
    logic           mem_wr;
    logic [7:0]     mem_dout;
    logic [7:0]     mem_din;
    logic           mem_ready;
    logic           err;

    // Responder view.
    modport slave (
        input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout, err
    );

    // Drive/track-loader and image-memory view.
    modport master (
        output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_din, mem_ready,
        input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
               mem_addr, mem_rd, mem_wr, mem_dout, err
    );

endinterface

// File: rtl/c1541_sd_responder.sv
// rtl/c1541_sd_responder.sv - whole-track SD request responder between disk image and track buffer
// Optional C1541_SD_RESP_WP_EN adds img_wp: write-protected images reject writes with err.
module c1541_sd_responder
    import c1541_sd_pkg::*;
#(
    parameter int  TRACK_BYTES = TRACK_BYTES_DEF,
    parameter int  TRK_BITS    = 7,
    parameter int  NUM_TRACKS  = 84,
    localparam int BAW         = $clog2(TRACK_BYTES),
    localparam int MAW         = TRK_BITS + BAW
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef C1541_SD_RESP_WP_EN
    input  logic                      img_wp,
`endif
    c1541_sd_responder_if.slave       bus
);

    localparam logic [BAW-1:0] LAST_BYTE = BAW'(TRACK_BYTES - 1);

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                ack_prev_q;
    logic [BAW-1:0]      cnt_q, cnt_d;
    logic [TRK_BITS-1:0] index_q, index_d;
    logic                skip_q, skip_d;
    logic                phase_q, phase_d;
    logic [BAW-1:0]      buff_addr_q, buff_addr_d;
    logic [7:0]          buff_dout_q, buff_dout_d;
    logic                buff_wr_q, buff_wr_d;
    logic                mem_rd_q, mem_rd_d;
    logic                mem_wr_q, mem_wr_d;
    logic [7:0]          mem_dout_q, mem_dout_d;
    logic                err_q, err_d;

    logic [TRK_BITS-1:0] lba_idx;
    logic                out_of_range;
    logic                wp_in;
    logic                last_byte;
    logic [MAW-1:0]      mem_addr;
    logic                unused_lba;

    assign lba_idx      = bus.sd_lba[TRK_BITS-1:0];
    assign unused_lba   = ^bus.sd_lba[31:TRK_BITS];
    assign out_of_range = 32'(lba_idx) >= 32'(NUM_TRACKS);
    assign last_byte    = cnt_q == LAST_BYTE;
    assign mem_addr     = {index_q, cnt_q};

`ifdef C1541_SD_RESP_WP_EN
    assign wp_in = img_wp;
`else
    assign wp_in = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        ack_d       = ack_q;
        cnt_d       = cnt_q;
        index_d     = index_q;
        skip_d      = skip_q;
        phase_d     = phase_q;
        buff_addr_d = buff_addr_q;
        buff_dout_d = buff_dout_q;
        buff_wr_d   = 1'b0;
        mem_rd_d    = mem_rd_q;
        mem_wr_d    = mem_wr_q;
        mem_dout_d  = mem_dout_q;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ack_prev_q guarantees the requester sees ack low for a full clock.
                if ((bus.sd_rd || bus.sd_wr) && !ack_prev_q) begin
                    index_d     = lba_idx;
                    cnt_d       = '0;
                    ack_d       = 1'b1;
                    buff_addr_d = '0;
                    phase_d     = 1'b0;
                    if (bus.sd_wr) begin
                        skip_d  = out_of_range || wp_in;
                        err_d   = out_of_range || wp_in;
                        state_d = ST_WR_ADDR;
                    end else begin
                        skip_d   = out_of_range;
                        err_d    = out_of_range;
                        mem_rd_d = !out_of_range;
                        state_d  = ST_RD_REQ;
                    end
                end
            end
            ST_RD_REQ: begin
                if (skip_q || bus.mem_ready) begin
                    buff_dout_d = skip_q ? FILL_BYTE : bus.mem_din;
                    buff_addr_d = cnt_q;
                    buff_wr_d   = 1'b1;
                    mem_rd_d    = 1'b0;
                    state_d     = ST_RD_GAP;
                end
            end
            ST_RD_GAP: begin
                if (last_byte) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d    = cnt_q + 1'b1;
                    mem_rd_d = !skip_q;
                    state_d  = ST_RD_REQ;
                end
            end
            ST_WR_ADDR: begin
                phase_d = 1'b0;
                state_d = ST_WR_DATA;
            end
            ST_WR_DATA: begin
                // First cycle captures buffer data; the strobe follows from the register.
                if (!phase_q) begin
                    mem_dout_d = bus.sd_buff_din;
                    mem_wr_d   = !skip_q;
                    phase_d    = 1'b1;
                end else if (skip_q || bus.mem_ready) begin
                    mem_wr_d = 1'b0;
                    state_d  = ST_WR_GAP;
                end
            end
            ST_WR_GAP: begin
                if (last_byte) begin
                    state_d = ST_FINISH;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
                    buff_addr_d = cnt_q + 1'b1;
                    state_d     = ST_WR_ADDR;
                end
            end
            ST_FINISH: begin
                ack_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                ack_d    = 1'b0;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ack_q       <= 1'b0;
            ack_prev_q  <= 1'b0;
            cnt_q       <= '0;
            index_q     <= '0;
            skip_q      <= 1'b0;
            phase_q     <= 1'b0;
            buff_addr_q <= '0;
            buff_dout_q <= '0;
            buff_wr_q   <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            mem_dout_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            ack_prev_q  <= ack_q;
            cnt_q       <= cnt_d;
            index_q     <= index_d;
            skip_q      <= skip_d;
            phase_q     <= phase_d;
            buff_addr_q <= buff_addr_d;
            buff_dout_q <= buff_dout_d;
            buff_wr_q   <= buff_wr_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            mem_dout_q  <= mem_dout_d;
            err_q       <= err_d;
        end
    end

    assign bus.sd_ack       = ack_q;
    assign bus.sd_buff_addr = buff_addr_q;
    assign bus.sd_buff_dout = buff_dout_q;
    assign bus.sd_buff_wr   = buff_wr_q;
    assign bus.mem_addr     = mem_addr;
    assign bus.mem_rd       = mem_rd_q;
    assign bus.mem_wr       = mem_wr_q;
    assign bus.mem_dout     = mem_dout_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_c1541_sd_responder.sv
// tb/tb_c1541_sd_responder.sv - scoreboard bench for c1541_sd_responder (C1541_SD_RESP_WP_EN optional)
module tb_c1541_sd_responder;

    localparam int TRACK_BYTES = 1024;
    localparam int TRK_BITS    = 7;
    localparam int NUM_TRACKS  = 84;
    localparam int BAW         = $clog2(TRACK_BYTES);
    localparam int MAW         = TRK_BITS + BAW;
    localparam int MEM_SIZE    = 1 << MAW;
    localparam int ACK_LIMIT   = TRACK_BYTES * 12;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    c1541_sd_responder_if #(.BAW(BAW), .MAW(MAW)) bus ();

`ifdef C1541_SD_RESP_WP_EN
    logic img_wp = 1'b0;
`endif

    c1541_sd_responder #(
        .TRACK_BYTES(TRACK_BYTES),
        .TRK_BITS   (TRK_BITS),
        .NUM_TRACKS (NUM_TRACKS)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef C1541_SD_RESP_WP_EN
        .img_wp(img_wp),
`endif
        .bus   (bus)
    );

    logic [7:0] mem     [MEM_SIZE];
    logic [7:0] img_exp [MEM_SIZE];
    logic [7:0] buff    [TRACK_BYTES];
    exp_t       rd_q[$];
    exp_t       wr_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int buff_wr_cnt = 0;
    int mem_rd_cycles = 0;
    int mem_wr_cycles = 0;
    int mem_wr_commits = 0;
    int err_cycles = 0;
    int ack_falls = 0;
    int gap_viol = 0;
    int max_lat = 0;
    int lat_left = 0;
    logic ack_d1 = 1'b0;
    logic done_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) bus.sd_buff_din <= buff[bus.sd_buff_addr];

    // Track-buffer and image-memory models plus protocol monitors.
    always @(negedge clk) begin
        exp_t e;
        if (bus.sd_buff_wr) begin
            buff[bus.sd_buff_addr] = bus.sd_buff_dout;
            buff_wr_cnt++;
            if (rd_q.size() == 0) begin
                check("buf_unexpected", 1, 0);
            end else begin
                e = rd_q.pop_front();
                check("buf_addr", 32'(bus.sd_buff_addr), e.addr);
                check("buf_data", 32'(bus.sd_buff_dout), 32'(e.data));
            end
        end
        if (bus.mem_rd) mem_rd_cycles++;
        if (bus.mem_wr) mem_wr_cycles++;
        if (bus.err) err_cycles++;
        if (ack_d1 && !bus.sd_ack) ack_falls++;
        ack_d1 = bus.sd_ack;
        if ((bus.mem_rd || bus.mem_wr) && done_prev) gap_viol++;

        if (reset) begin
            bus.mem_ready = 1'b0;
            lat_left = 0;
        end else if (bus.mem_ready) begin
            bus.mem_ready = 1'b0;
        end else if (bus.mem_rd || bus.mem_wr) begin
            if (lat_left == 0) begin
                bus.mem_ready = 1'b1;
                if (bus.mem_rd) bus.mem_din = mem[bus.mem_addr];
                if (bus.mem_wr) begin
                    mem[bus.mem_addr] = bus.mem_dout;
                    mem_wr_commits++;
                    if (wr_q.size() == 0) begin
                        check("mem_unexpected", 1, 0);
                    end else begin
                        e = wr_q.pop_front();
                        check("mem_addr", 32'(bus.mem_addr), e.addr);
                        check("mem_data", 32'(bus.mem_dout), 32'(e.data));
                    end
                end
                lat_left = $urandom_range(0, max_lat);
            end else begin
                lat_left--;
            end
        end
        done_prev = (bus.mem_rd || bus.mem_wr) && bus.mem_ready;
    end

    task automatic push_read(input int idx);
        for (int b = 0; b < TRACK_BYTES; b++) begin
            exp_t e;
            e.addr = 32'(b);
            e.data = (idx < NUM_TRACKS) ? img_exp[idx * TRACK_BYTES + b] : 8'h00;
            rd_q.push_back(e);
        end
    endtask

    task automatic push_write(input int idx);
        for (int b = 0; b < TRACK_BYTES; b++) begin
            exp_t e;
            e.addr = 32'(idx * TRACK_BYTES + b);
            e.data = buff[b];
            wr_q.push_back(e);
            img_exp[idx * TRACK_BYTES + b] = buff[b];
        end
    endtask

    function automatic int img_diff();
        int n = 0;
        for (int a = 0; a < MEM_SIZE; a++)
            if (mem[a] !== img_exp[a]) n++;
        return n;
    endfunction

    task automatic start_req(input int lba, input bit rd, input bit wr, output int lat);
        bus.sd_lba = 32'(lba);
        bus.sd_rd  = rd;
        bus.sd_wr  = wr;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.sd_ack && lat < 64);
        check("ack_rise", 32'(bus.sd_ack), 1);
    endtask

    task automatic wait_ack_low(output int cyc);
        cyc = 0;
        while (bus.sd_ack && cyc < ACK_LIMIT) begin
            @(negedge clk);
            cyc++;
        end
        check("ack_fall", 32'(bus.sd_ack), 0);
    endtask

    task automatic simple_req(input int lba, input bit rd, input bit wr, output int lat, output int width);
        start_req(lba, rd, wr, lat);
        bus.sd_rd = 1'b0;
        bus.sd_wr = 1'b0;
        wait_ack_low(width);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, width, gap, t, mism;
        int bw0, err0, fall0, rd0, wr0, com0;

        bus.sd_lba    = '0;
        bus.sd_rd     = 1'b0;
        bus.sd_wr     = 1'b0;
        bus.mem_ready = 1'b0;
        bus.mem_din   = '0;
        for (int a = 0; a < MEM_SIZE; a++) mem[a] = 8'($urandom);
        for (int b = 0; b < TRACK_BYTES; b++) mem[18 * TRACK_BYTES + b] = 8'(b) ^ 8'h5A;
        for (int a = 0; a < MEM_SIZE; a++) img_exp[a] = mem[a];
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = 8'h00;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(bus.sd_ack), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_mem_rd", 32'(bus.mem_rd), 0);
        check("rst_mem_wr", 32'(bus.mem_wr), 0);
        check("rst_buff_wr", 32'(bus.sd_buff_wr), 0);
        check("rst_buff_addr", 32'(bus.sd_buff_addr), 0);
        check("rst_mem_addr", 32'(bus.mem_addr), 0);
        check("rst_dout", 32'(bus.sd_buff_dout), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Read of track 18 with zero-latency memory.
        max_lat = 0;
        bw0 = buff_wr_cnt; err0 = err_cycles; fall0 = ack_falls;
        push_read(18);
        simple_req(18, 1'b1, 1'b0, lat, width);
        check("rd18_ack_lat", 32'(lat), 1);
        check("rd18_ack_width_min", 32'(width >= 2 * TRACK_BYTES), 1);
        check("rd18_buff_writes", 32'(buff_wr_cnt - bw0), TRACK_BYTES);
        check("rd18_ack_falls", 32'(ack_falls - fall0), 1);
        check("rd18_err", 32'(err_cycles - err0), 0);
        check("rd18_queue", 32'(rd_q.size()), 0);
        mism = 0;
        for (int b = 0; b < TRACK_BYTES; b++) if (buff[b] !== (8'(b) ^ 8'h5A)) mism++;
        check("rd18_buff_content", 32'(mism), 0);

        // Write of track 35 with random memory latency.
        max_lat = 3;
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = ~8'(b);
        err0 = err_cycles;
        push_write(35);
        simple_req(35, 1'b0, 1'b1, lat, width);
        check("wr35_queue", 32'(wr_q.size()), 0);
        check("wr35_err", 32'(err_cycles - err0), 0);
        check("wr35_image", 32'(img_diff()), 0);

        // Read and write together: write first, then the pending read.
        max_lat = 1;
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = 8'(b * 3 + 1);
        bw0 = buff_wr_cnt; com0 = mem_wr_commits;
        push_write(5);
        start_req(5, 1'b1, 1'b1, lat);
        bus.sd_wr = 1'b0;
        wait_ack_low(width);
        check("both_first_is_write", 32'(mem_wr_commits - com0), TRACK_BYTES);
        check("both_first_no_buff", 32'(buff_wr_cnt - bw0), 0);
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = 8'hEE;
        push_read(5);
        gap = 0;
        while (!bus.sd_ack && gap < 64) begin
            gap++;
            @(negedge clk);
        end
        check("both_ack_gap", 32'(gap >= 2), 1);
        check("both_second_ack", 32'(bus.sd_ack), 1);
        bus.sd_rd = 1'b0;
        wait_ack_low(width);
        repeat (2) @(negedge clk);
        check("both_rd_queue", 32'(rd_q.size()), 0);
        check("both_rd_count", 32'(buff_wr_cnt - bw0), TRACK_BYTES);
        check("both_image", 32'(img_diff()), 0);

        // Reset in the middle of a read.
        max_lat = 0;
        bw0 = buff_wr_cnt;
        push_read(18);
        start_req(18, 1'b1, 1'b0, lat);
        bus.sd_rd = 1'b0;
        t = 0;
        while (buff_wr_cnt - bw0 < 100 && t < ACK_LIMIT) begin
            @(posedge clk);
            t++;
        end
        check("rst_mid_reached", 32'(buff_wr_cnt - bw0 >= 100), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_ack", 32'(bus.sd_ack), 0);
        check("rst_mid_buff_wr", 32'(bus.sd_buff_wr), 0);
        check("rst_mid_mem_rd", 32'(bus.mem_rd), 0);
        reset = 1'b0;
        rd_q.delete();
        bw0 = buff_wr_cnt; rd0 = mem_rd_cycles;
        repeat (4) @(negedge clk);
        check("rst_mid_quiet_buff", 32'(buff_wr_cnt - bw0), 0);
        check("rst_mid_quiet_mem", 32'(mem_rd_cycles - rd0), 0);
        push_read(18);
        simple_req(18, 1'b1, 1'b0, lat, width);
        check("rst_after_queue", 32'(rd_q.size()), 0);
        check("rst_after_count", 32'(buff_wr_cnt - bw0), TRACK_BYTES);

        // Out-of-range read and write.
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = 8'hFF;
        bw0 = buff_wr_cnt; err0 = err_cycles; rd0 = mem_rd_cycles;
        push_read(90);
        simple_req(90, 1'b1, 1'b0, lat, width);
        check("oor_rd_err", 32'(err_cycles - err0), 1);
        check("oor_rd_mem_rd", 32'(mem_rd_cycles - rd0), 0);
        check("oor_rd_count", 32'(buff_wr_cnt - bw0), TRACK_BYTES);
        check("oor_rd_queue", 32'(rd_q.size()), 0);
        err0 = err_cycles; wr0 = mem_wr_cycles;
        simple_req(90, 1'b0, 1'b1, lat, width);
        check("oor_wr_err", 32'(err_cycles - err0), 1);
        check("oor_wr_mem_wr", 32'(mem_wr_cycles - wr0), 0);
        check("oor_wr_image", 32'(img_diff()), 0);

`ifdef C1541_SD_RESP_WP_EN
        max_lat = 2;
        for (int b = 0; b < TRACK_BYTES; b++) buff[b] = 8'(b) ^ 8'hC3;
        img_wp = 1'b1;
        err0 = err_cycles; wr0 = mem_wr_cycles;
        simple_req(2, 1'b0, 1'b1, lat, width);
        check("wp_err", 32'(err_cycles - err0), 1);
        check("wp_mem_wr", 32'(mem_wr_cycles - wr0), 0);
        check("wp_image", 32'(img_diff()), 0);
        img_wp = 1'b0;
        err0 = err_cycles;
        push_write(2);
        simple_req(2, 1'b0, 1'b1, lat, width);
        check("wp_off_err", 32'(err_cycles - err0), 0);
        check("wp_off_queue", 32'(wr_q.size()), 0);
        check("wp_off_image", 32'(img_diff()), 0);
`endif

        check("strobe_gap", 32'(gap_viol), 0);
        check("final_wr_queue", 32'(wr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
